// File: rtl/bus_hold_arbiter_if.sv
// Bus-side signals of the 8088 HOLD/HLDA arbiter. The arbiter uses the
// master modport; the processor model and requesters use the slave modport.
interface bus_hold_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
) ();

  logic               HLDA;
  logic [NUM_REQ-1:0] REQ;
  logic               HOLD;
  logic [NUM_REQ-1:0] GNT;
  logic               BUSY;
  logic               TIMEOUT;

  modport master (
    input  HLDA,
    input  REQ,
    output HOLD,
    output GNT,
    output BUSY,
    output TIMEOUT
  );

  modport slave (
    output HLDA,
    output REQ,
    input  HOLD,
    input  GNT,
    input  BUSY,
    input  TIMEOUT
  );

endinterface

// File: rtl/bus_hold_arbiter.sv
// Round-robin arbiter sharing the 8088 local bus between the CPU and NUM_REQ
// bus masters via HOLD/HLDA. Each tenure is bounded by MAX_HOLD_CYCLES and
// followed by at least GAP_CYCLES of CPU ownership. All outputs registered.
module bus_hold_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned MAX_HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES      = 4
) (
  input logic                CLK,
  input logic                RESET,
  bus_hold_arbiter_if.master bus
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_HOLD_CYCLES + 1);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitAck,
    StGrant,
    StRelease,
    StGap
  } state_e;

  state_e             state_q, state_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [PtrW-1:0]    win_q, win_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic               hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [PtrW-1:0]    scan_idx;
  logic [PtrW-1:0]    pick;
  logic               pick_vld;

  // Modulo-NUM_REQ increment for requester indices.
  function automatic logic [PtrW-1:0] next_idx(input logic [PtrW-1:0] i);
    return (i == PtrW'(NUM_REQ - 1)) ? '0 : i + PtrW'(1);
  endfunction

  // Round-robin search: first active request at or above ptr_q, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && bus.REQ[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
      scan_idx = next_idx(scan_idx);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          hold_d  = 1'b1;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (!pick_vld) begin
          // Everyone withdrew before the CPU let go of the bus.
          hold_d  = 1'b0;
          state_d = StRelease;
        end else if (bus.HLDA) begin
          win_d        = pick;
          gnt_d        = '0;
          gnt_d[pick]  = 1'b1;
          cnt_d        = '0;
          state_d      = StGrant;
        end
      end
      StGrant: begin
        cnt_d = cnt_q + CntW'(1);
        // A lost HLDA is handled like the owner dropping its request.
        if (!bus.HLDA || !bus.REQ[win_q]) begin
          gnt_d   = '0;
          hold_d  = 1'b0;
          ptr_d   = next_idx(win_q);
          state_d = StRelease;
        end else if (cnt_q == CntW'(MAX_HOLD_CYCLES - 1)) begin
          gnt_d     = '0;
          hold_d    = 1'b0;
          ptr_d     = next_idx(win_q);
          timeout_d = 1'b1;
          state_d   = StRelease;
        end
      end
      StRelease: begin
        if (!bus.HLDA) begin
          gap_d   = GapW'(GAP_CYCLES);
          state_d = StGap;
        end
      end
      StGap: begin
        gap_d = gap_q - GapW'(1);
        if (gap_q == GapW'(1)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = 1'b0;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      hold_q    <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.HOLD    = hold_q;
  assign bus.GNT     = gnt_q;
  assign bus.BUSY    = busy_q;
  assign bus.TIMEOUT = timeout_q;

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Self-checking bench for bus_hold_arbiter: a behavioural bus-ownership model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_bus_hold_arbiter;

  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned GAP      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_hold_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  bus_hold_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .MAX_HOLD_CYCLES(MAX_HOLD),
    .GAP_CYCLES     (GAP)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  // Processor: HLDA follows HOLD two cycles later; kill forces it low.
  logic h1 = 1'b0, hp = 1'b0, kill = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  always @(posedge clk) begin
    h1 <= (bus.HOLD === 1'b1);
    hp <= h1;
  end
  assign bus.HLDA = hp & ~kill;
  assign bus.REQ  = req;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 cpu owns bus, 1 asking cpu, 2 requester owns bus,
  //        3 waiting for cpu to take back, 4 cpu-only gap
  int phase = 0, owner = 0, held = 0, gap_left = 0, rr = 0;
  logic m_hold = 1'b0, m_busy = 1'b0, m_to = 1'b0;
  logic [NUM_REQ-1:0] m_gnt = '0;
  logic hlda_s = 1'b0;
  logic rst_at_edge = 1'b0;

  function automatic int pick_rr(input logic [NUM_REQ-1:0] r, input int start);
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      int i;
      i = (start + k) % int'(NUM_REQ);
      if (((r >> i) & 1) != 0) return i;
    end
    return 0;
  endfunction

  task automatic end_tenure(input logic to);
    m_gnt  = '0;
    m_hold = 1'b0;
    m_to   = to;
    rr     = (owner + 1) % int'(NUM_REQ);
    phase  = 3;
  endtask

  // Advance the model on every rising edge using the values the DUT samples.
  always @(posedge clk) begin
    hlda_s      = bus.HLDA;
    rst_at_edge = rst;
    if (rst) begin
      phase = 0; rr = 0; m_hold = 1'b0; m_gnt = '0; m_to = 1'b0; m_busy = 1'b0;
    end else begin
      m_to = 1'b0;
      case (phase)
        0: if (bus.REQ != 0) begin phase = 1; m_hold = 1'b1; end
        1: begin
          if (bus.REQ == 0) begin
            phase = 3; m_hold = 1'b0;
          end else if (bus.HLDA) begin
            owner = pick_rr(bus.REQ, rr);
            m_gnt = NUM_REQ'(1) << owner;
            held  = 1;
            phase = 2;
          end
        end
        2: begin
          if (!bus.HLDA || (((bus.REQ >> owner) & 1) == 0)) end_tenure(1'b0);
          else if (held == int'(MAX_HOLD)) end_tenure(1'b1);
          else held = held + 1;
        end
        3: if (!bus.HLDA) begin gap_left = int'(GAP); phase = 4; end
        4: begin
          gap_left = gap_left - 1;
          if (gap_left == 0) phase = 0;
        end
        default: phase = 0;
      endcase
      m_busy = (phase != 0);
    end
  end

  // ---------------- compare + monitors ----------------
  bit checking = 1'b0;
  logic [NUM_REQ-1:0] gnt_prev = '0;
  logic hold_prev = 1'b0;
  int cur_len = 0, to_count = 0, low_run = 0;
  bit gap_armed = 1'b0;
  int lens[$];
  logic [NUM_REQ-1:0] grants[$];

  // Check the DUT against the model and invariants at every falling edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("hold", bus.HOLD, m_hold);
      chk("gnt", bus.GNT, m_gnt);
      chk("busy", bus.BUSY, m_busy);
      chk("timeout", bus.TIMEOUT, m_to);
      chk("gnt_at_most_one", $countones(bus.GNT) <= 1, 1);
      if (bus.GNT != 0) chk("gnt_needs_hold", bus.HOLD, 1);
      if (gnt_prev == 0 && bus.GNT != 0) begin
        chk("gnt_hlda_at_edge", hlda_s, 1);
        grants.push_back(bus.GNT);
      end
      if (bus.GNT != 0) cur_len = cur_len + 1;
      else if (gnt_prev != 0) begin
        lens.push_back(cur_len);
        cur_len = 0;
      end
      if (bus.TIMEOUT) to_count = to_count + 1;

      if (rst_at_edge) begin
        gap_armed = 1'b0;
        low_run   = 0;
      end else begin
        if (!bus.HOLD && !bus.HLDA) low_run = low_run + 1;
        else if (bus.HOLD) begin
          if (!hold_prev && gap_armed) chk("gap_before_hold", low_run >= int'(GAP), 1);
          if (!hold_prev) gap_armed = 1'b0;
          low_run = 0;
        end else low_run = 0;
        if (hold_prev && !bus.HOLD) gap_armed = 1'b1;
      end
    end
    gnt_prev  = bus.GNT;
    hold_prev = bus.HOLD;
  end

  // ---------------- directed scenarios ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnt(input string name);
    int n = 0;
    while (bus.GNT == 0 && n < 60) begin
      cyc(1);
      n++;
    end
    chk(name, bus.GNT != 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.BUSY !== 1'b0 && n < 100) begin
      cyc(1);
      n++;
    end
    chk(name, bus.BUSY, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    int base, lb, t0, n;
    logic [NUM_REQ-1:0] g;
    req = '0; kill = 1'b0; rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    checking = 1'b1;
    chk("reset_hold", bus.HOLD, 0);
    chk("reset_gnt", bus.GNT, 0);
    chk("reset_busy", bus.BUSY, 0);
    chk("reset_timeout", bus.TIMEOUT, 0);

    // Single request, five granted cycles.
    req = 2'b01;
    cyc(1);
    chk("s1_hold_after_req", bus.HOLD, 1);
    chk("s1_no_gnt_yet", bus.GNT, 0);
    cyc(3);
    chk("s1_gnt_latency", bus.GNT, 2'b01);
    cyc(4);
    req = 2'b00;
    cyc(1);
    chk("s1_release", {bus.HOLD, bus.GNT, bus.TIMEOUT}, 0);
    wait_idle("s1_idle");
    chk("s1_len", lens[lens.size()-1], 5);
    chk("s1_no_timeout", to_count, 0);
    req = 2'b11;
    wait_gnt("s1_ptr_gnt");
    chk("s1_ptr_is_1", bus.GNT, 2'b10);
    req = 2'b00;
    wait_idle("s1_idle2");

    // Round robin, three-cycle tenures.
    do_reset();
    base = grants.size();
    lb   = lens.size();
    req  = 2'b11;
    for (int t = 0; t < 3; t++) begin
      wait_gnt("s2_gnt");
      g = bus.GNT;
      cyc(2);
      req = req & ~g;
      cyc(1);
      req = 2'b11;
    end
    req = 2'b00;
    wait_idle("s2_idle");
    chk("s2_count", grants.size() - base, 3);
    if (grants.size() - base >= 3) begin
      chk("s2_g0", grants[base], 2'b01);
      chk("s2_g1", grants[base+1], 2'b10);
      chk("s2_g2", grants[base+2], 2'b01);
    end
    if (lens.size() - lb >= 3) chk("s2_len", lens[lb+2], 3);

    // Timeout twice.
    do_reset();
    base = grants.size();
    lb   = lens.size();
    t0   = to_count;
    req  = 2'b01;
    n    = 0;
    while (to_count - t0 < 2 && n < 200) begin
      cyc(1);
      n++;
    end
    req = 2'b00;
    wait_idle("s3_idle");
    chk("s3_timeouts", to_count - t0, 2);
    chk("s3_len_count", lens.size() - lb, 2);
    if (lens.size() - lb >= 2) begin
      chk("s3_len0", lens[lb], 16);
      chk("s3_len1", lens[lb+1], 16);
    end
    if (grants.size() - base >= 2) chk("s3_regrant", grants[base+1], 2'b01);

    // Withdraw before acknowledge.
    do_reset();
    base = grants.size();
    req  = 2'b01;
    cyc(1);
    chk("s4_hold", bus.HOLD, 1);
    req = 2'b00;
    cyc(1);
    chk("s4_hold_dropped", bus.HOLD, 0);
    wait_idle("s4_idle");
    chk("s4_no_gnt", grants.size() - base, 0);

    // Reset mid-tenure.
    do_reset();
    req = 2'b10;
    wait_gnt("s5_gnt");
    chk("s5_gnt_is_10", bus.GNT, 2'b10);
    cyc(2);
    rst = 1'b1;
    req = 2'b00;
    cyc(1);
    chk("s5_rst_hold", bus.HOLD, 0);
    chk("s5_rst_gnt", bus.GNT, 0);
    chk("s5_rst_busy", bus.BUSY, 0);
    chk("s5_rst_timeout", bus.TIMEOUT, 0);
    rst = 1'b0;
    cyc(3);
    req = 2'b11;
    wait_gnt("s5_regnt");
    chk("s5_ptr0", bus.GNT, 2'b01);
    req = 2'b00;
    wait_idle("s5_idle");

    // HLDA lost during a tenure.
    do_reset();
    t0  = to_count;
    req = 2'b01;
    wait_gnt("s6_gnt");
    cyc(2);
    kill = 1'b1;
    cyc(1);
    chk("s6_gnt_drop", bus.GNT, 0);
    chk("s6_hold_drop", bus.HOLD, 0);
    chk("s6_no_to_pulse", bus.TIMEOUT, 0);
    req = 2'b00;
    n = 0;
    while (bus.BUSY && n < 20) begin
      n++;
      cyc(1);
    end
    chk("s6_busy_cycles", n, 5);
    kill = 1'b0;
    chk("s6_no_timeout", to_count - t0, 0);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
